// File: rtl/btb_branch_predictor_pkg.sv
// Shared definitions for the BTB next-PC predictor.
//   - upd_kind_e : classification of one EX-stage update against the BTB.
//   - cnt_weak_taken / cnt_weak_not_taken : direction counter encodings
//     derived from the counter width (MSB=1 means predict taken).
package btb_branch_predictor_pkg;

    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,  // no update, or a not-taken miss (entry left alone)
        UPD_TRAIN = 2'd1,  // hit: move the counter, refresh target if taken
        UPD_ALLOC = 2'd2   // taken miss: overwrite the entry
    } upd_kind_e;

    // Weakly-taken = MSB set, rest clear; weakly-not-taken is one below it.
    // Written as a shift so it also holds for a 1-bit counter.
    function automatic logic [31:0] cnt_weak_taken(input int cnt_bits);
        return 32'd1 << (cnt_bits - 1);
    endfunction

    function automatic logic [31:0] cnt_weak_not_taken(input int cnt_bits);
        return (32'd1 << (cnt_bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/btb_branch_predictor_if.sv
// Fetch/update bus between the pipeline and the BTB predictor.
//   master : pipeline side (drives pc, force_pc*, upd_*; reads predictions)
//   slave  : predictor side
// Handshake: there is no backpressure. upd_valid qualifies upd_* for exactly
// the cycle it is high and is consumed on that rising edge; the lookup
// signals (pc -> next_pc/pred_hit/pred_taken) are purely combinational.
interface btb_branch_predictor_if #(
    parameter int WORD_SIZE = 16
);
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] next_pc;
    logic                 pred_hit;
    logic                 pred_taken;
    logic                 force_pc;
    logic [WORD_SIZE-1:0] force_pc_data;
    logic                 upd_valid;
    logic [WORD_SIZE-1:0] upd_pc;
    logic                 upd_taken;
    logic [WORD_SIZE-1:0] upd_target;
    logic                 upd_mispredict;

    modport master (
        output pc, force_pc, force_pc_data,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  next_pc, pred_hit, pred_taken
    );

    modport slave (
        input  pc, force_pc, force_pc_data,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output next_pc, pred_hit, pred_taken
    );
endinterface

// File: rtl/btb_branch_predictor_sat_counter.sv
// bp_sat_counter: next value of a CNT_BITS saturating up/down counter.
//   cnt : current value
//   up  : 1 = count up (taken), 0 = count down (not taken)
//   nxt : next value; holds at all-ones going up and at zero going down
module bp_sat_counter #(
    parameter int CNT_BITS = 2
) (
    input  logic [CNT_BITS-1:0] cnt,
    input  logic                up,
    output logic [CNT_BITS-1:0] nxt
);
    always_comb begin
        nxt = cnt;
        if (up) begin
            if (cnt != {CNT_BITS{1'b1}}) nxt = cnt + CNT_BITS'(1);
        end else begin
            if (cnt != '0) nxt = cnt - CNT_BITS'(1);
        end
    end
endmodule

// File: rtl/btb_branch_predictor.sv
// btb_branch_predictor: direct-mapped BTB with per-entry saturating direction
// counters. Combinational lookup for IF, clocked update from EX resolution.
// Ports:
//   clk, reset_n        : clock (rising edge), asynchronous active-low reset
//   bus (slave)         : pc/next_pc/pred_hit/pred_taken, force_pc redirect,
//                         upd_* resolution from EX
//   stat_updates        : count of update cycles (BP_STATS_EN only, else 0)
//   stat_mispredicts    : count of mispredicting updates (BP_STATS_EN only)
//   upd_kind_dbg        : classification of the current update (debug)
// Optional feature: define BP_STATS_EN to build the statistics counters.
module btb_branch_predictor
    import btb_branch_predictor_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4,
    parameter int CNT_BITS   = 2,
    parameter int STAT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    btb_branch_predictor_if.slave bus,
    output logic [STAT_BITS-1:0]  stat_updates,
    output logic [STAT_BITS-1:0]  stat_mispredicts,
    output upd_kind_e             upd_kind_dbg
);
    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(cnt_weak_taken(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'(cnt_weak_not_taken(CNT_BITS));

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

    // ---------------- lookup ----------------
    logic [INDEX_BITS-1:0] l_idx;
    logic [TAG_W-1:0]      l_tag;
    logic                  l_hit;
    logic                  l_taken;

    assign l_idx   = bus.pc[INDEX_BITS-1:0];
    assign l_tag   = bus.pc[WORD_SIZE-1:INDEX_BITS];
    assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign l_taken = l_hit && cnt_q[l_idx][CNT_BITS-1];

    always_comb begin
        bus.next_pc    = '0;
        bus.pred_hit   = 1'b0;
        bus.pred_taken = 1'b0;
        if (reset_n) begin
            bus.pred_hit   = l_hit;
            bus.pred_taken = l_taken;
            if (bus.force_pc)  bus.next_pc = bus.force_pc_data;
            else if (l_taken)  bus.next_pc = target_q[l_idx];
            else               bus.next_pc = bus.pc + WORD_SIZE'(1);
        end
    end

    // ---------------- update ----------------
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]      u_tag;
    logic                  u_hit;
    logic [CNT_BITS-1:0]   u_cnt_nxt;

    assign u_idx = bus.upd_pc[INDEX_BITS-1:0];
    assign u_tag = bus.upd_pc[WORD_SIZE-1:INDEX_BITS];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    bp_sat_counter #(.CNT_BITS(CNT_BITS)) u_sat (
        .cnt (cnt_q[u_idx]),
        .up  (bus.upd_taken),
        .nxt (u_cnt_nxt)
    );

    always_comb begin
        upd_kind_dbg = UPD_NONE;
        if (bus.upd_valid) begin
            if (u_hit)              upd_kind_dbg = UPD_TRAIN;
            else if (bus.upd_taken) upd_kind_dbg = UPD_ALLOC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
        end else begin
            case (upd_kind_dbg)
                UPD_TRAIN: cnt_q[u_idx] <= u_cnt_nxt;
                UPD_ALLOC: begin
                    valid_q[u_idx] <= 1'b1;
                    cnt_q[u_idx]   <= CNT_WT;
                end
                default: ;
            endcase
        end
    end

    // Tag/target are not reset; valid gates them. Any taken update (train or
    // allocate) writes both - on a hit the tag rewrite is the same value.
    always_ff @(posedge clk) begin
        if (reset_n && bus.upd_valid && bus.upd_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bus.upd_target;
        end
    end

    // ---------------- statistics ----------------
`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (bus.upd_valid) begin
            stat_updates <= stat_updates + STAT_BITS'(1);
            if (bus.upd_mispredict) stat_mispredicts <= stat_mispredicts + STAT_BITS'(1);
        end
    end
`else
    logic unused_stat_inputs;
    assign unused_stat_inputs = bus.upd_mispredict;
    assign stat_updates       = '0;
    assign stat_mispredicts   = '0;
`endif

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Directed bench for btb_branch_predictor (WORD_SIZE=16, INDEX_BITS=4,
// CNT_BITS=2). Expected values are hand-computed constants.
module tb_btb_branch_predictor;
    import btb_branch_predictor_pkg::*;

    logic clk;
    logic reset_n;
    logic [15:0] stat_updates;
    logic [15:0] stat_mispredicts;
    upd_kind_e   upd_kind_dbg;
    int checks;
    int errors;

    btb_branch_predictor_if #(.WORD_SIZE(16)) bus ();

    btb_branch_predictor #(
        .WORD_SIZE(16), .INDEX_BITS(4), .CNT_BITS(2), .STAT_BITS(16)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus.slave),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts),
        .upd_kind_dbg     (upd_kind_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One update cycle: present upd_* and let one edge consume it.
    task automatic upd(input logic [15:0] a, input logic tk, input logic [15:0] tgt,
                       input logic mp);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = a;
        bus.upd_taken      = tk;
        bus.upd_target     = tgt;
        bus.upd_mispredict = mp;
        tick();
        bus.upd_valid      = 1'b0;
        bus.upd_mispredict = 1'b0;
    endtask

    task automatic look(input string tag, input logic [15:0] a, input logic hit,
                        input logic tk, input logic [15:0] npc);
        bus.pc = a;
        #1;
        check({tag, "_hit"},   {15'd0, bus.pred_hit},   {15'd0, hit});
        check({tag, "_taken"}, {15'd0, bus.pred_taken}, {15'd0, tk});
        check({tag, "_npc"},   bus.next_pc, npc);
    endtask

    logic [15:0] exp_upd;
    logic [15:0] exp_mis;

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        reset_n            = 1'b0;
        bus.pc             = 16'h0010;
        bus.force_pc       = 1'b0;
        bus.force_pc_data  = 16'h0000;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = 16'h0000;
        bus.upd_taken      = 1'b0;
        bus.upd_target     = 16'h0000;
        bus.upd_mispredict = 1'b0;
`ifdef BP_STATS_EN
        exp_upd = 16'd5;
        exp_mis = 16'd2;
`else
        exp_upd = 16'd0;
        exp_mis = 16'd0;
`endif
        #1;
        check("rst_npc",   bus.next_pc, 16'h0000);
        check("rst_hit",   {15'd0, bus.pred_hit}, 16'd0);
        check("rst_taken", {15'd0, bus.pred_taken}, 16'd0);
        tick();
        tick();
        check("rst_stat_u", stat_updates, 16'd0);
        check("rst_stat_m", stat_mispredicts, 16'd0);
        reset_n = 1'b1;
        #1;
        check("rel_npc", bus.next_pc, 16'h0011);

        // allocation and tag discrimination
        upd(16'h0023, 1'b1, 16'h0040, 1'b0);            // cnt 10
        look("alloc", 16'h0023, 1'b1, 1'b1, 16'h0040);
        look("othertag", 16'h0013, 1'b0, 1'b0, 16'h0014);

        // hysteresis
        upd(16'h0023, 1'b0, 16'h0000, 1'b0);            // 01
        look("hy_nt1", 16'h0023, 1'b1, 1'b0, 16'h0024);
        upd(16'h0023, 1'b1, 16'h0040, 1'b0);            // 10
        look("hy_t1", 16'h0023, 1'b1, 1'b1, 16'h0040);
        upd(16'h0023, 1'b1, 16'h0040, 1'b0);            // 11
        upd(16'h0023, 1'b1, 16'h0040, 1'b0);            // 11 (sat)
        upd(16'h0023, 1'b1, 16'h0040, 1'b0);            // 11 (sat)
        upd(16'h0023, 1'b0, 16'h0000, 1'b0);            // 10
        look("hy_sat_nt", 16'h0023, 1'b1, 1'b1, 16'h0040);
        upd(16'h0023, 1'b0, 16'h0000, 1'b0);            // 01
        look("hy_nt2", 16'h0023, 1'b1, 1'b0, 16'h0024);
        upd(16'h0023, 1'b0, 16'h0000, 1'b0);            // 00
        upd(16'h0023, 1'b0, 16'h0000, 1'b0);            // 00 (floor)
        upd(16'h0023, 1'b1, 16'h0040, 1'b0);            // 01
        look("hy_floor", 16'h0023, 1'b1, 1'b0, 16'h0024);

        // same-edge lookup and update: old contents until the edge
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 16'h0023;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 16'h0077;
        look("same_pre", 16'h0023, 1'b1, 1'b0, 16'h0024);
        tick();                                         // 10, target 0077
        bus.upd_valid = 1'b0;
        look("same_post", 16'h0023, 1'b1, 1'b1, 16'h0077);

        // force_pc overrides a taken hit; hit/taken unaffected
        bus.force_pc      = 1'b1;
        bus.force_pc_data = 16'h0100;
        look("force", 16'h0023, 1'b1, 1'b1, 16'h0100);
        bus.force_pc      = 1'b0;

        // not-taken miss leaves the entry invalid; wrap of pc+1
        upd(16'h0055, 1'b0, 16'h0099, 1'b0);
        look("nt_miss", 16'h0055, 1'b0, 1'b0, 16'h0056);
        look("wrap", 16'hFFFF, 1'b0, 1'b0, 16'h0000);

        // asynchronous reset mid-cycle clears the BTB
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_npc", bus.next_pc, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        look("arst_clear", 16'h0023, 1'b0, 1'b0, 16'h0024);

        // statistics: 5 updates, 2 mispredicting
        upd(16'h0030, 1'b0, 16'h0000, 1'b1);
        upd(16'h0031, 1'b0, 16'h0000, 1'b0);
        upd(16'h0032, 1'b0, 16'h0000, 1'b1);
        upd(16'h0033, 1'b0, 16'h0000, 1'b0);
        upd(16'h0034, 1'b0, 16'h0000, 1'b0);
        tick();
        check("stat_u", stat_updates, exp_upd);
        check("stat_m", stat_mispredicts, exp_mis);

        // reset mid-update: counters clear at once, update is discarded
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = 16'h0036;
        bus.upd_taken      = 1'b1;
        bus.upd_target     = 16'h0200;
        bus.upd_mispredict = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("stat_rst_u", stat_updates, 16'd0);
        check("stat_rst_m", stat_mispredicts, 16'd0);
        tick();
        bus.upd_valid      = 1'b0;
        bus.upd_mispredict = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        look("rst_discard", 16'h0036, 1'b0, 1'b0, 16'h0037);
        check("stat_after_u", stat_updates, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
